// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, fetches words over imem req/ack and
// hands each instruction to decode over valid/ready, honouring next-PC redirects.
module fetch_pc_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redir_valid,
    input  logic [1:0]       redir_sel,
    input  logic [WIDTH-1:0] redir_pc,
    input  logic [15:0]      redir_imm,
    input  logic [25:0]      redir_jidx,
    input  logic [WIDTH-1:0] redir_reg,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    input  logic             instr_ready,
    output logic             addr_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_OUT  = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic             addr_err_q, addr_err_d;
    logic             imem_req_q, imem_req_d;
    logic             instr_valid_q, instr_valid_d;
    logic [WIDTH-1:0] target_s;
    logic             jr_misaligned_s;

    // Redirect target for the selected next-PC source
    always_comb begin
        target_s        = RESET_PC;
        jr_misaligned_s = 1'b0;
        case (redir_sel)
            2'd0: target_s = RESET_PC;
            2'd1: target_s = redir_pc + {{(WIDTH-18){redir_imm[15]}}, redir_imm, 2'b00};
            2'd2: target_s = {redir_pc[WIDTH-1:WIDTH-4], redir_jidx, 2'b00};
            2'd3: begin
                target_s        = {redir_reg[WIDTH-1:2], 2'b00};
                jr_misaligned_s = (redir_reg[1:0] != 2'b00);
            end
            default: target_s = RESET_PC;
        endcase
    end

    // Next-state: the PC only moves outside an outstanding request, so imem_addr stays stable until ack
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        addr_err_d = addr_err_q | (redir_valid & jr_misaligned_s);
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (imem_ack && redir_valid) begin
                    pc_d    = target_s;
                    state_d = ST_REQ;
                end else if (imem_ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = ST_OUT;
                end else if (redir_valid) begin
                    pend_d  = target_s;
                    state_d = ST_DROP;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                if (imem_ack) begin
                    pc_d    = redir_valid ? target_s : pend_q;
                    state_d = ST_REQ;
                end else if (redir_valid) begin
                    pend_d  = target_s;
                    state_d = ST_DROP;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_OUT: begin
                if (redir_valid) begin
                    pc_d    = target_s;
                    state_d = ST_REQ;
                end else if (instr_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        imem_req_d    = (state_d == ST_REQ) || (state_d == ST_DROP);
        instr_valid_d = (state_d == ST_OUT);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            pend_q        <= {WIDTH{1'b0}};
            instr_q       <= {WIDTH{1'b0}};
            instr_pc_q    <= {WIDTH{1'b0}};
            addr_err_q    <= 1'b0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_q        <= pend_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            addr_err_q    <= addr_err_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: a memory model tags each word with its
// address, and every delivered instruction is checked against the expected queue.
module tb_fetch_pc_unit;

    localparam logic [31:0] MAGIC = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redir_valid;
    logic [1:0]  redir_sel;
    logic [31:0] redir_pc;
    logic [15:0] redir_imm;
    logic [25:0] redir_jidx;
    logic [31:0] redir_reg;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        addr_err;

    int nvec = 0;
    int nerr = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    bit drop_pend = 1'b0;
    int n_acc = 0;
    logic [31:0] exp_pc_q[$];
    logic [31:0] acc_q[$];

    always #5 clk = ~clk;

    fetch_pc_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .redir_valid(redir_valid), .redir_sel(redir_sel), .redir_pc(redir_pc),
        .redir_imm(redir_imm), .redir_jidx(redir_jidx), .redir_reg(redir_reg),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .instr_ready(instr_ready), .addr_err(addr_err)
    );

    // One clock: memory response, scoreboard push/pop, then advance to the next negedge.
    task automatic step();
        logic [31:0] e;
        if (!rst && imem_req === 1'b1 && wait_cnt >= ack_delay) begin
            imem_ack   = 1'b1;
            imem_rdata = imem_addr ^ MAGIC;
            wait_cnt   = 0;
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            wait_cnt   = (!rst && imem_req === 1'b1) ? wait_cnt + 1 : 0;
        end
        if (rst) drop_pend = 1'b0;
        if (!rst && imem_ack && !redir_valid && !drop_pend) exp_pc_q.push_back(imem_addr);
        if (!rst && imem_req === 1'b1 && !imem_ack && redir_valid) drop_pend = 1'b1;
        else if (imem_ack) drop_pend = 1'b0;
        if (!rst && instr_valid === 1'b1 && (instr_ready || redir_valid)) begin
            nvec++;
            if (exp_pc_q.size() == 0) begin
                nerr++;
                $display("FAIL sb_underflow: delivered pc=%h instr=%h, none expected", instr_pc, instr);
            end else begin
                e = exp_pc_q.pop_front();
                if (instr_pc !== e || instr !== (e ^ MAGIC)) begin
                    nerr++;
                    $display("FAIL sb_instr: got pc=%h instr=%h, want pc=%h instr=%h",
                             instr_pc, instr, e, e ^ MAGIC);
                end
                if (instr_ready && !redir_valid) begin
                    n_acc++;
                    acc_q.push_back(instr_pc);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        redir_valid = 1'b0;
        imem_ack    = 1'b0;
    endtask

    task automatic redirect(input logic [1:0] sel, input logic [31:0] pc, input logic [15:0] imm,
                            input logic [25:0] jidx, input logic [31:0] rg);
        redir_valid = 1'b1;
        redir_sel   = sel;
        redir_pc    = pc;
        redir_imm   = imm;
        redir_jidx  = jidx;
        redir_reg   = rg;
    endtask

    task automatic check_fetch(input string name, input logic [31:0] addr, input logic exp_err);
        nvec++;
        if (imem_req !== 1'b1 || imem_addr !== addr || instr_valid !== 1'b0 || addr_err !== exp_err) begin
            nerr++;
            $display("FAIL %s: got req=%b addr=%h valid=%b err=%b, want req=1 addr=%h valid=0 err=%b",
                     name, imem_req, imem_addr, instr_valid, addr_err, addr, exp_err);
        end
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) step();
        if (instr_valid !== 1'b1) begin
            nvec++;
            nerr++;
            $display("FAIL %s_timeout: instr_valid=%b after 20 cycles, want 1", name, instr_valid);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        exp_pc_q.delete();
        acc_q.delete();
        n_acc     = 0;
        drop_pend = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            nvec++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 ||
                addr_err !== 1'b0 || imem_addr !== 32'h0) begin
                nerr++;
                $display("FAIL reset_state: req=%b valid=%b instr=%h pc=%h err=%b addr=%h, want all 0",
                         imem_req, instr_valid, instr, instr_pc, addr_err, imem_addr);
            end
        end
        rst = 1'b0;
        step();
        check_fetch("first_req", 32'h0, 1'b0);
    endtask

    task automatic test_sequential();
        instr_ready = 1'b1;
        for (int i = 0; i < 30 && n_acc < 4; i++) step();
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (acc_q.size() <= i || acc_q[i] !== 32'(i * 4)) begin
                nerr++;
                $display("FAIL seq_pc[%0d]: got %h (accepted %0d), want %h", i,
                         (acc_q.size() > i) ? acc_q[i] : 32'hX, acc_q.size(), 32'(i * 4));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 30 && n_acc < 2; i++) step();
        instr_ready = 1'b0;
        wait_valid("bp");
        for (int i = 0; i < 5; i++) begin
            nvec++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'h8 || instr !== (32'h8 ^ MAGIC) || imem_req !== 1'b0) begin
                nerr++;
                $display("FAIL bp_hold[%0d]: valid=%b pc=%h instr=%h req=%b, want 1 %h %h 0",
                         i, instr_valid, instr_pc, instr, imem_req, 32'h8, 32'h8 ^ MAGIC);
            end
            step();
        end
        instr_ready = 1'b1;
        step();
        check_fetch("bp_next", 32'hC, 1'b0);
    endtask

    task automatic test_branch();
        instr_ready = 1'b0;
        wait_valid("br");
        redirect(2'd1, 32'h100, 16'hFFFE, 26'h0, 32'h0);
        step();
        check_fetch("branch_addr", 32'hF8, 1'b0);
        wait_valid("br2");
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
    endtask

    task automatic test_pending_redirect();
        ack_delay = 3;
        check_fetch("pend_first", 32'hFC, 1'b0);
        redirect(2'd2, 32'h0, 16'h0, 26'h000_0040, 32'h0);
        step();
        for (int k = 0; k < 3; k++) begin
            check_fetch("pend_hold", 32'hFC, 1'b0);
            step();
        end
        check_fetch("pend_target", 32'h100, 1'b0);
    endtask

    task automatic test_overrides();
        ack_delay = 0;
        redirect(2'd0, 32'h0, 16'h0, 26'h0, 32'h0);
        step();
        check_fetch("req_ack_redir", 32'h0, 1'b0);
        ack_delay = 2;
        redirect(2'd2, 32'h0, 16'h0, 26'h000_0080, 32'h0);
        step();
        check_fetch("drop_hold", 32'h0, 1'b0);
        redirect(2'd3, 32'h0, 16'h0, 26'h0, 32'h300);
        step();
        step();
        check_fetch("drop_latest", 32'h300, 1'b0);
        redirect(2'd2, 32'h0, 16'h0, 26'h000_0010, 32'h0);
        step();
        step();
        redirect(2'd1, 32'h400, 16'h0001, 26'h0, 32'h0);
        step();
        check_fetch("drop_ack_redir", 32'h404, 1'b0);
        ack_delay = 0;
    endtask

    task automatic test_jr_misaligned();
        instr_ready = 1'b0;
        wait_valid("jr");
        instr_ready = 1'b1;
        redirect(2'd3, 32'h0, 16'h0, 26'h0, 32'h203);
        step();
        check_fetch("jr_addr", 32'h200, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            nvec++;
            if (addr_err !== 1'b1) begin
                nerr++;
                $display("FAIL jr_sticky[%0d]: addr_err=%b, want 1", i, addr_err);
            end
        end
    endtask

    task automatic test_wrap();
        instr_ready = 1'b0;
        wait_valid("wrap");
        redirect(2'd3, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC);
        step();
        check_fetch("wrap_top", 32'hFFFF_FFFC, 1'b1);
        wait_valid("wrap2");
        instr_ready = 1'b1;
        step();
        check_fetch("wrap_zero", 32'h0, 1'b1);
    endtask

    task automatic test_final_reset();
        rst = 1'b1;
        step();
        nvec++;
        if (addr_err !== 1'b0 || instr_valid !== 1'b0 || imem_req !== 1'b0 || instr_pc !== 32'h0) begin
            nerr++;
            $display("FAIL rst_clears: err=%b valid=%b req=%b pc=%h, want 0 0 0 0",
                     addr_err, instr_valid, imem_req, instr_pc);
        end
        rst = 1'b0;
        exp_pc_q.delete();
    endtask

    initial begin
        rst         = 1'b1;
        redir_valid = 1'b0;
        redir_sel   = 2'd0;
        redir_pc    = 32'h0;
        redir_imm   = 16'h0;
        redir_jidx  = 26'h0;
        redir_reg   = 32'h0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch();
        test_pending_redirect();
        test_overrides();
        test_jr_misaligned();
        test_wrap();
        test_final_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch front end of the MIPS datapath. Holds the program counter, issues word fetches to instruction memory over a req/ack handshake, and presents each fetched instruction to decode over a valid/ready handshake. It consumes the next-PC selection (sequential, branch, jump, jump-register) that the decode/execute stages drive through a 4:1 select code.

## Interface
- `WIDTH`, 32: address/data width; must be 32.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset and redirect target for select 0; must be word aligned.

- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `redir_valid`, in, 1: one-cycle redirect request.
- `redir_sel`, in, 2: next-PC select.
  - 0 = `RESET_PC`
  - 1 = branch
  - 2 = jump
  - 3 = jr
- `redir_pc`, in, 32: PC+4 of the redirecting instruction.
- `redir_imm`, in, 16: branch offset in words, signed.
- `redir_jidx`, in, 26: jump index.
- `redir_reg`, in, 32: jr register value.
- `imem_req`, out, 1: fetch request.
- `imem_addr`, out, 32: fetch address.
- `imem_ack`, in, 1: fetch complete; `imem_rdata` is valid this cycle.
- `imem_rdata`, in, 32: fetched word.
- `instr_valid`, out, 1: `instr` and `instr_pc` are valid.
- `instr`, out, 32: fetched instruction.
- `instr_pc`, out, 32: address of `instr`.
- `instr_ready`, in, 1: decode accepts the instruction.
- `addr_err`, out, 1: sticky flag; a misaligned jr target was seen.

## Operation
- **States:** IDLE, REQ, OUT, DROP.
- **Outputs by state:**
  - `imem_req` = 1 in REQ and DROP.
  - `instr_valid` = 1 in OUT only.
  - `imem_addr` = `pc` at all times.
- **Reset:** while `rst` is high, next state is IDLE.
  - `pc` = `RESET_PC`, `instr` = 0, `instr_pc` = 0, `addr_err` = 0, pending redirect cleared.
  - Outputs during and right after reset: `imem_req` = 0, `instr_valid` = 0.
- **IDLE:** goes to REQ unconditionally on the first edge with `rst` low.
- **REQ:**
  - On `imem_ack`: capture `instr` ← `imem_rdata` and `instr_pc` ← `pc`, then go to OUT.
  - If `redir_valid` is high and no ack: latch the target into the pending register and go to DROP. `pc` is not changed, because the address must stay stable until ack.
  - If `redir_valid` and `imem_ack` are high together: discard the data, `pc` ← target, stay in REQ.
- **DROP:** waits for `imem_ack` and discards the data.
  - Then `pc` ← pending target and go to REQ.
  - A further redirect while in DROP overwrites the pending target; the latest redirect wins.
  - A redirect in the same cycle as the ack also wins over the pending target: `pc` ← new target.
- **OUT:**
  - `instr_ready` high, no redirect: `pc` ← `pc` + 4 (mod 2^32), go to REQ.
  - `redir_valid` high: the held instruction is dropped, or counts as consumed if `instr_ready` is also high. `pc` ← target, go to REQ.
  - Otherwise: hold all outputs stable.
- **Target computation** (combinational from `redir_*`):
  - sel 0: `RESET_PC`.
  - sel 1: `redir_pc` + (sign-extended `redir_imm` << 2), mod 2^32.
  - sel 2: {`redir_pc`[31:28], `redir_jidx`, 2'b00}.
  - sel 3: `redir_reg` with bits [1:0] forced to 0. If `redir_reg`[1:0] != 0, `addr_err` ← 1 and it stays set until reset.
- **Sequential wrap:** `pc` = 32'hFFFF_FFFC followed by +4 gives 32'h0000_0000.

## Timing
- **Fetch latency:** `imem_req` rises the cycle after leaving reset. With a zero-wait memory (ack in the same cycle as req), `instr_valid` rises on the next cycle.
- **Throughput:** at most one instruction per 2 cycles (REQ → OUT → REQ).
- **Stall:** `instr_valid` stays high and `instr`/`instr_pc` stay constant until accepted or redirected.
- **Request stability:** `imem_addr` is constant from the rise of `imem_req` until `imem_ack`.
- **Redirect timing:** a redirect takes effect on the edge where it is sampled. The first request to the new target is issued in the following cycle, or after the outstanding ack when in DROP.
- **Reset mid-operation:** any state goes to IDLE on the next edge. An outstanding request is abandoned and any late ack is ignored.

## Test plan
- **Reset/sequential:** `RESET_PC` = 0, memory acks every request with data = address ^ 32'hA5A5_0000, `instr_ready` = 1.
  - Required: `instr_pc` sequence 0, 4, 8, 12.
  - Required: each `instr` equals its pc ^ 32'hA5A5_0000.
  - Required: no `instr_valid` during reset.
- **Backpressure:** `instr_ready` held low for 5 cycles in OUT at pc 8.
  - Required: `instr` and `instr_pc` = 8 stable and `imem_req` = 0 throughout.
  - Required: after ready, the next request is to 12.
- **Branch:** redirect sel 1 with `redir_pc` = 32'h100 and imm = 16'hFFFE, issued in OUT.
  - Required: next `imem_addr` = 32'hF8.
  - Required: the held instruction is never accepted.
- **Redirect during pending fetch:** ack delayed 3 cycles, sel 2 redirect with jidx = 26'h000_0040 (`redir_pc`[31:28] = 0) in the first REQ cycle.
  - Required: `imem_addr` is unchanged until ack.
  - Required: the data is dropped with no `instr_valid`.
  - Required: the next request is to 32'h100.
- **jr misaligned:** sel 3 with `redir_reg` = 32'h203.
  - Required: fetch from 32'h200.
  - Required: `addr_err` = 1 and stays 1 until `rst`.
- **Wrap:** sel 3 redirect to 32'hFFFF_FFFC, then accept.
  - Required: the next fetch is to 32'h0.
